// File: rtl/nrzi_rx_decoder_if.sv
// Line-side samples in, decoded bit stream and framing strobes out.
// bit_cnt exists only when NRZI_RX_BITCNT_EN is defined.
interface nrzi_rx_decoder_if;
  logic        nrzi_in;
  logic        sample_valid;
  logic        se0;
  logic        bit_out;
  logic        bit_valid;
  logic        sop;
  logic        eop;
  logic        stuff_err;
  logic        rx_active;
`ifdef NRZI_RX_BITCNT_EN
  logic [15:0] bit_cnt;
`endif

  modport master (
    output nrzi_in, sample_valid, se0,
`ifdef NRZI_RX_BITCNT_EN
    input  bit_cnt,
`endif
    input  bit_out, bit_valid, sop, eop, stuff_err, rx_active
  );

  modport slave (
    input  nrzi_in, sample_valid, se0,
`ifdef NRZI_RX_BITCNT_EN
    output bit_cnt,
`endif
    output bit_out, bit_valid, sop, eop, stuff_err, rx_active
  );
endinterface

// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder: SYNC hunt, bit unstuffing, stuff-error and SE0 framing; optional bit_cnt via NRZI_RX_BITCNT_EN.
// All outputs registered, one cycle after the qualifying sample; no backpressure (sample_valid paced input).
module nrzi_rx_decoder #(
  parameter int STUFF_LEN      = 6,
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic              clk,
  input  logic              reset,
  nrzi_rx_decoder_if.slave  bus
);

  localparam int OC_W = $clog2(STUFF_LEN + 1);
  localparam logic [OC_W-1:0] ONE_INC = OC_W'(1);
  localparam logic [3:0]      ZERO_INC = 4'd1;

  typedef enum logic [1:0] {
    S_HUNT,
    S_DATA,
    S_ABORT,
    S_EOP_WAIT
  } state_t;

  state_t          r_state, w_state;
  logic            r_prev_level, w_prev_level;
  logic [3:0]      r_zero_cnt, w_zero_cnt;
  logic [OC_W-1:0] r_one_cnt, w_one_cnt;
  logic            r_bit_out, w_bit_out;
  logic            r_bit_valid, w_bit_valid;
  logic            r_sop, w_sop;
  logic            r_eop, w_eop;
  logic            r_stuff_err, w_stuff_err;
  logic            r_rx_active, w_rx_active;
  logic            w_dec;

  assign w_dec = ~(bus.nrzi_in ^ r_prev_level);

  always_comb begin
    w_state      = r_state;
    w_prev_level = r_prev_level;
    w_zero_cnt   = r_zero_cnt;
    w_one_cnt    = r_one_cnt;
    w_bit_out    = 1'b0;
    w_bit_valid  = 1'b0;
    w_sop        = 1'b0;
    w_eop        = 1'b0;
    w_stuff_err  = 1'b0;

    if (bus.sample_valid) begin
      w_prev_level = bus.se0 ? 1'b1 : bus.nrzi_in;
      case (r_state)
        S_HUNT: begin
          if (bus.se0) begin
            w_zero_cnt = '0;
          end else if (!w_dec) begin
            if (r_zero_cnt != 4'hF) w_zero_cnt = r_zero_cnt + ZERO_INC;
          end else if (int'(r_zero_cnt) >= SYNC_MIN_ZEROS) begin
            // SYNC-ending 1 seeds the stuffing run but is not delivered
            w_sop      = 1'b1;
            w_one_cnt  = ONE_INC;
            w_zero_cnt = '0;
            w_state    = S_DATA;
          end else begin
            w_zero_cnt = '0;
          end
        end
        S_DATA: begin
          if (bus.se0) begin
            w_eop   = 1'b1;
            w_state = S_EOP_WAIT;
          end else if (int'(r_one_cnt) == STUFF_LEN) begin
            if (w_dec) begin
              w_stuff_err = 1'b1;
              w_state     = S_ABORT;
            end else begin
              w_one_cnt = '0;
            end
          end else begin
            w_bit_valid = 1'b1;
            w_bit_out   = w_dec;
            w_one_cnt   = w_dec ? r_one_cnt + ONE_INC : '0;
          end
        end
        S_ABORT: begin
          if (bus.se0) w_state = S_EOP_WAIT;
        end
        S_EOP_WAIT: begin
          if (!bus.se0) begin
            w_zero_cnt = '0;
            w_state    = S_HUNT;
          end
        end
        default: w_state = S_HUNT;
      endcase
    end

    // Held through the eop strobe cycle, dropped on the cycle after
    w_rx_active = (w_state == S_DATA) || w_eop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_HUNT;
      r_prev_level <= 1'b1;
      r_zero_cnt   <= '0;
      r_one_cnt    <= '0;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_rx_active  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_prev_level <= w_prev_level;
      r_zero_cnt   <= w_zero_cnt;
      r_one_cnt    <= w_one_cnt;
      r_bit_out    <= w_bit_out;
      r_bit_valid  <= w_bit_valid;
      r_sop        <= w_sop;
      r_eop        <= w_eop;
      r_stuff_err  <= w_stuff_err;
      r_rx_active  <= w_rx_active;
    end
  end

  assign bus.bit_out   = r_bit_out;
  assign bus.bit_valid = r_bit_valid;
  assign bus.sop       = r_sop;
  assign bus.eop       = r_eop;
  assign bus.stuff_err = r_stuff_err;
  assign bus.rx_active = r_rx_active;

`ifdef NRZI_RX_BITCNT_EN
  logic [15:0] r_bit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt <= '0;
    end else if (w_sop) begin
      r_bit_cnt <= '0;
    end else if (w_bit_valid && (r_bit_cnt != 16'hFFFF)) begin
      r_bit_cnt <= r_bit_cnt + 16'd1;
    end
  end

  assign bus.bit_cnt = r_bit_cnt;
`endif

endmodule

// File: doc/nrzi_rx_decoder.md
Name: nrzi_rx_decoder

Overview:
- Receive-side counterpart of the team's NRZI transmit path.
- Takes sampled line levels, one per clock when valid, and NRZI-decodes them: no transition = 1, transition = 0.
- Hunts for the SYNC field, removes stuffed bits, flags bit-stuff violations and frames packets using an externally supplied SE0 indication.
- Feeds the downstream packet deserializer with a clean bit stream plus sop/eop strobes.

Parameters:
- STUFF_LEN, 6: consecutive decoded 1s after which the next bit must be a stuffed 0.
- SYNC_MIN_ZEROS, 5: minimum consecutive decoded 0s, immediately followed by a decoded 1, that is accepted as SYNC (tolerates hub-dropped SYNC bits).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- nrzi_in  input  1  sampled differential line level (1 = J).
- sample_valid  input  1  nrzi_in/se0 valid this clock.
- se0  input  1  single-ended-zero seen on this sample; qualified by sample_valid.
- bit_out  output  1  decoded, unstuffed data bit.
- bit_valid  output  1  bit_out valid (one-cycle strobe).
- sop  output  1  one-cycle strobe on the cycle SYNC completes.
- eop  output  1  one-cycle strobe on the first SE0 sample while in DATA.
- stuff_err  output  1  one-cycle strobe on a bit-stuff violation.
- rx_active  output  1  high from sop through the eop strobe cycle.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0.
  - prev_level = 1 (idle J), state = HUNT, all counters 0.
  - Reset mid-packet discards everything; no eop is generated.
- Decode:
  - On each sample_valid with se0 = 0: dec = ~(nrzi_in ^ prev_level), then prev_level <= nrzi_in.
  - A se0 sample forces prev_level <= 1.
  - Cycles with sample_valid = 0 change no state, and all strobes are 0.
- Latency: all outputs are registered. Responses appear the cycle after the qualifying sample.
- HUNT:
  - zero_cnt counts consecutive dec = 0, saturating at 15.
  - dec = 1 with zero_cnt >= SYNC_MIN_ZEROS: sop = 1, rx_active = 1, one_cnt <= 1, go to DATA. The SYNC-ending 1 counts toward stuffing but is not output.
  - dec = 1 with zero_cnt < SYNC_MIN_ZEROS: zero_cnt <= 0, stay in HUNT.
  - se0 in HUNT: zero_cnt <= 0, stay in HUNT (no eop).
- DATA:
  - se0: eop = 1, go to EOP_WAIT. rx_active drops the cycle after the eop strobe.
  - one_cnt == STUFF_LEN and dec = 0: stuffed bit. Drop it (bit_valid = 0), one_cnt <= 0.
  - one_cnt == STUFF_LEN and dec = 1: stuff_err = 1, rx_active <= 0, go to ABORT. No bit is output.
  - Otherwise: bit_valid = 1, bit_out = dec. one_cnt <= dec ? one_cnt + 1 : 0.
- ABORT: ignore data; the first se0 sample goes to EOP_WAIT with no eop strobe.
- EOP_WAIT:
  - Wait for a sample with se0 = 0, which must be J.
  - Then go to HUNT with zero_cnt <= 0, prev_level <= nrzi_in.
- Simultaneous events:
  - se0 takes priority over stuff checking.
  - stuff_err and eop are never asserted in the same cycle.
- Counter widths: one_cnt is clog2(STUFF_LEN+1) bits; zero_cnt is 4 bits, saturating.

Optional Feature:
- Macro NRZI_RX_BITCNT_EN.
- When defined:
  - Adds output bit_cnt, 16 bits, reset 0.
  - Cleared to 0 on the sop cycle.
  - +1 per bit_valid, saturating at 16'hFFFF.
  - Holds its value after eop/stuff_err until the next sop.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Idle J samples, then levels encoding SYNC 00000001 followed by data 1,0,1,1 -> exactly one sop the cycle after the last SYNC sample; bit_valid ×4 with bit_out 1,0,1,1; rx_active = 1.
- Data with six 1s, then stuffed 0, then 1 -> six bit_valid = 1 strobes, no strobe for the stuffed sample, then bit_out = 1; stuff_err stays 0.
- Data with seven consecutive 1s -> stuff_err pulses on the 7th, rx_active drops; subsequent samples produce no bit_valid; se0 then J -> back to HUNT with no eop.
- Packet, then two se0 samples, then J -> eop pulses once on the first se0; rx_active falls the next cycle; a second SYNC is then detected again.
- SYNC with only 4 leading zeros (SYNC_MIN_ZEROS = 5) -> no sop; SYNC with 5 leading zeros -> sop.
- Reset asserted mid-DATA for 1 cycle -> all outputs 0, prev_level = 1; the next packet decodes correctly. With NRZI_RX_BITCNT_EN, bit_cnt = 0 after reset and equals 4 after the 4-bit packet.
